ro_scan_ctrl: RTL and testbench

- Measurement sequencer for the ring-oscillator bank behind the RO_10 AXI4-Lite register interface.
- Enables one RO at a time and lets it settle. Opens a counter gate for a programmed window, then captures the edge count into a per-RO result bank.
- Walks all NUM_RO oscillators once, or repeatedly in continuous mode. The AXI register file supplies start/abort/window and reads results by index.

---
 rtl/ro_pkg.sv | 24 ++
 rtl/ro_result_bank.sv | 52 +++++
 rtl/ro_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ro_scan_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared definitions for the ring-oscillator scan sequencer and its
// register-interface neighbours: FSM state encoding, size defaults and the
// register map used by the AXI4-Lite front end.
package ro_pkg;

  localparam int NUM_RO_DEF = 10;
  localparam int CNT_W_DEF  = 32;

  // Register byte offsets seen by the AXI4-Lite register file
  localparam logic [3:0] REG_CTRL   = 4'h0;  // start / abort / continuous
  localparam logic [3:0] REG_WINDOW = 4'h4;  // gate window length
  localparam logic [3:0] REG_STATUS = 4'h8;  // busy / done / err_zero / cur_idx
  localparam logic [3:0] REG_RESULT = 4'hC;  // indexed result read

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_GATE   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_STORE  = 3'd4,
    ST_NEXT   = 3'd5
  } ro_scan_state_t;

endpackage

// File: rtl/ro_result_bank.sv
// Per-oscillator result storage: one write port driven by the sequencer and
// a registered read port for the register file. Out-of-range reads return 0.
module ro_result_bank
  import ro_pkg::*;
#(
  parameter int NUM_RO = NUM_RO_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_data
);

  logic [CNT_W-1:0] mem [NUM_RO];
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_in_range;

  // Extra bit keeps the bound check correct when NUM_RO == 2**IDX_W
  assign rd_in_range = {1'b0, rd_idx} < (IDX_W+1)'(NUM_RO);

  // Storage array has no reset; entries are undefined until first written
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Next read value; a same-cycle write is seen one cycle later
  always_comb begin
    rd_data_d = '0;
    if (rd_in_range) begin
      rd_data_d = mem[rd_idx];
    end
  end

  // Read register, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ro_scan_ctrl.sv
// Ring-oscillator measurement sequencer. Enables one oscillator at a time,
// lets it settle, gates the external counter for win cycles, waits for the
// count to cross back into this domain and stores it per oscillator.
// One down-counter times the settle, gate and hold phases.
module ro_scan_ctrl
  import ro_pkg::*;
#(
  parameter int NUM_RO     = NUM_RO_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WIN_W      = 24,
  parameter int SETTLE_CYC = 16,
  parameter int HOLD_CYC   = 4,
  parameter int IDX_W      = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  input  logic [WIN_W-1:0]  window_len,
  output logic [NUM_RO-1:0] ro_en,
  output logic              cnt_clr,
  output logic              cnt_gate,
  input  logic [CNT_W-1:0]  cnt_value,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [CNT_W-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  cur_idx,
  output logic [15:0]       scan_cnt,
  output logic              err_zero
);

  localparam logic [WIN_W-1:0] SETTLE_LOAD = WIN_W'(SETTLE_CYC - 1);
  localparam logic [WIN_W-1:0] HOLD_LOAD   = WIN_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_RO - 1);

  ro_scan_state_t   state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic [15:0]      scan_cnt_q, scan_cnt_d;
  logic             done_q, done_d;
  logic             err_zero_q, err_zero_d;
  logic             timer_zero;
  logic             ro_active;
  logic             store_en;

  assign timer_zero = (timer_q == '0);

  // Next-state and datapath updates; abort overrides every active state
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    win_d      = win_q;
    cur_idx_d  = cur_idx_q;
    scan_cnt_d = scan_cnt_q;
    done_d     = done_q;
    err_zero_d = err_zero_q;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            if (window_len == '0) begin
              err_zero_d = 1'b1;
            end else begin
              win_d      = window_len;
              done_d     = 1'b0;
              err_zero_d = 1'b0;
              cur_idx_d  = '0;
              timer_d    = SETTLE_LOAD;
              state_d    = ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (timer_zero) begin
            timer_d = win_q - 1'b1;
            state_d = ST_GATE;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_GATE: begin
          if (timer_zero) begin
            timer_d = HOLD_LOAD;
            state_d = ST_HOLD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (timer_zero) begin
            state_d = ST_STORE;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_STORE: begin
          state_d = ST_NEXT;
        end
        ST_NEXT: begin
          if (cur_idx_q != LAST_IDX) begin
            cur_idx_d = cur_idx_q + 1'b1;
            timer_d   = SETTLE_LOAD;
            state_d   = ST_SETTLE;
          end else begin
            scan_cnt_d = scan_cnt_q + 16'd1;
            if (continuous) begin
              cur_idx_d = '0;
              timer_d   = SETTLE_LOAD;
              state_d   = ST_SETTLE;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Sequencer state registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      win_q      <= '0;
      cur_idx_q  <= '0;
      scan_cnt_q <= '0;
      done_q     <= 1'b0;
      err_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      win_q      <= win_d;
      cur_idx_q  <= cur_idx_d;
      scan_cnt_q <= scan_cnt_d;
      done_q     <= done_d;
      err_zero_q <= err_zero_d;
    end
  end

  // Oscillator stays enabled from settle through hold; dropped at store
  assign ro_active = (state_q == ST_SETTLE) || (state_q == ST_GATE) ||
                     (state_q == ST_HOLD);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RO; gi++) begin : g_ro_en
      assign ro_en[gi] = ro_active && (cur_idx_q == IDX_W'(gi));
    end
  endgenerate

  // Clear only on the first settle cycle, so it can never overlap the gate
  assign cnt_clr  = (state_q == ST_SETTLE) && (timer_q == SETTLE_LOAD);
  assign cnt_gate = (state_q == ST_GATE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign err_zero = err_zero_q;
  assign cur_idx  = cur_idx_q;
  assign scan_cnt = scan_cnt_q;

  // A store coinciding with abort is discarded like any partial measurement
  assign store_en = (state_q == ST_STORE) && !abort;

  ro_result_bank #(
    .NUM_RO (NUM_RO),
    .CNT_W  (CNT_W),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk     (ACLK),
    .rst     (ARESET),
    .wr_en   (store_en),
    .wr_idx  (cur_idx_q),
    .wr_data (cnt_value),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_ro_scan_ctrl.sv
// Directed bench for ro_scan_ctrl: full scan timing, per-RO waveform shape,
// result readback, abort, zero-window error, continuous mode and async reset.
module tb_ro_scan_ctrl;

  logic        ACLK;
  logic        ARESET;
  logic        start;
  logic        abort;
  logic        continuous;
  logic [23:0] window_len;
  logic [9:0]  ro_en;
  logic        cnt_clr;
  logic        cnt_gate;
  logic [31:0] cnt_value;
  logic [3:0]  rd_idx;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic [3:0]  cur_idx;
  logic [15:0] scan_cnt;
  logic        err_zero;

  int n_chk  = 0;
  int n_pass = 0;

  // counter model: the external counter reports cnt_base + oscillator index
  logic [31:0] cnt_base = 32'd0;
  int          mon_idx  = 0;
  assign cnt_value = cnt_base + 32'(mon_idx);

  // per-activation waveform monitor
  logic [9:0] mon_prev = '0;
  int a_len, a_gate_at, a_gate_len, a_clr, a_clr_first;
  int last_len, last_gate_at, last_gate_len, last_clr, last_clr_first;
  int n_act    = 0;
  int mon_viol = 0;

  ro_scan_ctrl dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .start      (start),
    .abort      (abort),
    .continuous (continuous),
    .window_len (window_len),
    .ro_en      (ro_en),
    .cnt_clr    (cnt_clr),
    .cnt_gate   (cnt_gate),
    .cnt_value  (cnt_value),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .cur_idx    (cur_idx),
    .scan_cnt   (scan_cnt),
    .err_zero   (err_zero)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    forever begin
      @(negedge ACLK);
      if (ro_en != '0) begin
        if (mon_prev == '0) begin
          a_len = 0; a_gate_at = -1; a_gate_len = 0; a_clr = 0;
          a_clr_first = int'(cnt_clr);
        end
        if ($countones(ro_en) > 1) mon_viol++;
        if (cnt_gate && a_gate_at < 0) a_gate_at = a_len;
        if (cnt_gate) a_gate_len++;
        if (cnt_clr) a_clr++;
        a_len++;
        for (int i = 0; i < 10; i++) if (ro_en[i]) mon_idx = i;
      end else if (mon_prev != '0) begin
        last_len = a_len; last_gate_at = a_gate_at; last_gate_len = a_gate_len;
        last_clr = a_clr; last_clr_first = a_clr_first;
        n_act++;
      end
      if (cnt_gate && (cnt_clr || ro_en == '0)) mon_viol++;
      mon_prev = ro_en;
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
      $display("check %-16s got %0d", name, act);
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!done && cycles < limit);
  endtask

  task automatic read_chk(input string name, input logic [3:0] idx, input logic [31:0] exp);
    rd_idx = idx;
    tick();
    chk(name, rd_data, exp);
  endtask

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] exp;
  } rd_vec_t;

  typedef struct {
    logic [23:0] wl;
    logic        exp_err;
    logic        exp_busy;
    int          exp_cyc;
    logic [15:0] exp_scan;
  } start_vec_t;

  rd_vec_t    rd_tab[12];
  start_vec_t st_tab[3];

  initial begin
    int cyc;

    for (int i = 0; i < 10; i++) begin
      rd_tab[i].idx = 4'(i);
      rd_tab[i].exp = 32'd1000 + 32'(i);
    end
    rd_tab[10] = '{idx: 4'd10, exp: 32'd0};
    rd_tab[11] = '{idx: 4'd15, exp: 32'd0};

    // zero window rejected; short windows run 10*(16+wl+6) cycles
    st_tab[0] = '{wl: 24'd0, exp_err: 1'b1, exp_busy: 1'b0, exp_cyc: 0,   exp_scan: 16'd1};
    st_tab[1] = '{wl: 24'd5, exp_err: 1'b0, exp_busy: 1'b1, exp_cyc: 270, exp_scan: 16'd2};
    st_tab[2] = '{wl: 24'd1, exp_err: 1'b0, exp_busy: 1'b1, exp_cyc: 230, exp_scan: 16'd3};

    ARESET = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    window_len = '0; rd_idx = '0;
    repeat (3) tick();
    chk("rst_ro_en", ro_en, 0);
    chk("rst_cnt_clr", cnt_clr, 0);
    chk("rst_cnt_gate", cnt_gate, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cur_idx", cur_idx, 0);
    chk("rst_scan_cnt", scan_cnt, 0);
    chk("rst_err_zero", err_zero, 0);
    chk("rst_rd_data", rd_data, 0);
    ARESET = 1'b0;
    tick();

    // full scan, window 100
    window_len = 24'd100;
    cnt_base   = 32'd1000;
    pulse_start();
    chk("scan1_busy", busy, 1);
    chk("scan1_done_clr", done, 0);
    wait_done(2000, cyc);
    chk("scan1_cycles", cyc, 1220);
    chk("scan1_done", done, 1);
    chk("scan1_busy_end", busy, 0);
    chk("scan1_scan_cnt", scan_cnt, 1);
    chk("mon_activations", n_act, 10);
    chk("mon_ro_len", last_len, 120);
    chk("mon_gate_at", last_gate_at, 16);
    chk("mon_gate_len", last_gate_len, 100);
    chk("mon_clr_cycles", last_clr, 1);
    chk("mon_clr_first", last_clr_first, 1);
    chk("mon_viol", mon_viol, 0);
    for (int i = 0; i < 12; i++) begin
      read_chk($sformatf("result[%0d]", rd_tab[i].idx), rd_tab[i].idx, rd_tab[i].exp);
    end

    // abort during RO 2 gate, with a simultaneous start that must lose
    cnt_base = 32'd2000;
    pulse_start();
    repeat (300) tick();
    chk("abt_pre_gate", cnt_gate, 1);
    chk("abt_pre_idx", cur_idx, 2);
    abort = 1'b1; start = 1'b1; window_len = 24'd7;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abt_gate", cnt_gate, 0);
    chk("abt_ro_en", ro_en, 0);
    chk("abt_busy", busy, 0);
    chk("abt_done", done, 0);
    chk("abt_scan_cnt", scan_cnt, 1);
    repeat (3) tick();
    chk("abt_stay_idle", busy, 0);
    read_chk("abt_result0", 4'd0, 32'd2000);
    read_chk("abt_result1", 4'd1, 32'd2001);
    read_chk("abt_result2", 4'd2, 32'd1002);
    read_chk("abt_result3", 4'd3, 32'd1003);

    // start vectors; window_len is disturbed after each start
    for (int i = 0; i < 3; i++) begin
      window_len = st_tab[i].wl;
      pulse_start();
      window_len = 24'd50;
      chk($sformatf("st%0d_err_zero", i), err_zero, st_tab[i].exp_err);
      chk($sformatf("st%0d_busy", i), busy, st_tab[i].exp_busy);
      if (st_tab[i].exp_cyc > 0) begin
        wait_done(st_tab[i].exp_cyc + 100, cyc);
        chk($sformatf("st%0d_cycles", i), cyc, st_tab[i].exp_cyc);
        chk($sformatf("st%0d_done", i), done, 1);
      end
      chk($sformatf("st%0d_scan_cnt", i), scan_cnt, st_tab[i].exp_scan);
    end

    // continuous for 2.5 scans of 270 cycles, with an ignored start
    window_len = 24'd5;
    continuous = 1'b1;
    pulse_start();
    window_len = 24'd0;
    for (int c = 1; c <= 675; c++) begin
      start = (c == 100);
      window_len = (c == 100) ? 24'd200 : 24'd0;
      tick();
    end
    start = 1'b0;
    chk("cont_done_mid", done, 0);
    chk("cont_busy_mid", busy, 1);
    chk("cont_scan_mid", scan_cnt, 5);
    continuous = 1'b0;
    wait_done(1000, cyc);
    chk("cont_cycles_rest", cyc, 135);
    chk("cont_done", done, 1);
    chk("cont_scan_cnt", scan_cnt, 6);

    // async reset in the middle of RO 0 gate
    window_len = 24'd100;
    pulse_start();
    repeat (20) tick();
    chk("ar_pre_gate", cnt_gate, 1);
    ARESET = 1'b1;
    #1;
    chk("ar_ro_en", ro_en, 0);
    chk("ar_cnt_gate", cnt_gate, 0);
    chk("ar_cnt_clr", cnt_clr, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_cur_idx", cur_idx, 0);
    chk("ar_scan_cnt", scan_cnt, 0);
    chk("ar_err_zero", err_zero, 0);
    chk("ar_rd_data", rd_data, 0);
    tick();
    ARESET = 1'b0;
    tick();
    window_len = 24'd2;
    pulse_start();
    wait_done(400, cyc);
    chk("ar_run_cycles", cyc, 240);
    chk("ar_run_done", done, 1);
    chk("ar_run_scan", scan_cnt, 1);
    chk("mon_viol_final", mon_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
